seq_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 24 ++
 rtl/divider_step.sv | 33 +++
 rtl/seq_divider.sv | 133 +++++++++++++
 tb/tb_seq_divider.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider.
//   state_t        : controller state encoding (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  : default operand/result width
//   cnt_width()    : width of the bit counter, clog2(width)
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter holds WIDTH-1 down to 0. The counter is never narrower than one
  // bit, so WIDTH=2 still gets a usable register.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division step.
// Ports:
//   rem_in   [WIDTH-1:0] : partial remainder before this step
//   bit_in               : next dividend bit (MSB-first)
//   divisor  [WIDTH-1:0] : divisor
//   rem_out  [WIDTH-1:0] : partial remainder after this step
//   q_bit                : quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit so the shifted remainder can never wrap before the compare.
  logic [WIDTH:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});

  // When the subtraction is taken, shifted < 2*divisor, so the difference is
  // below divisor and fits in WIDTH bits; the low-bit subtract is exact.
  assign rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative unsigned restoring divider, one quotient bit per clock, with a
// start/ready/done handshake. An accepted request produces done in the
// WIDTH+1-th cycle counted from the accept edge; a new request may be accepted
// in the DONE cycle, giving one division every WIDTH+1 cycles.
// Divide by zero takes the normal path: quotient = all ones,
// remainder = dividend.
//
// Optional feature (macro DIVIDER_DBZ_ERR_EN):
//   adds output dbz, latched at accept as (divisor == 0) and presented with
//   the results at done.
//
// Ports:
//   clk                     : clock, rising edge
//   rst                     : synchronous active-high reset
//   start                   : request, honoured only while ready=1
//   dividend  [WIDTH-1:0]   : numerator, latched at accept
//   divisor   [WIDTH-1:0]   : denominator, latched at accept
//   ready                   : can accept (IDLE or DONE)
//   done                    : one-cycle result-valid pulse
//   quotient  [WIDTH-1:0]   : result, held until the next done
//   remainder [WIDTH-1:0]   : result, held until the next done
//   dbz                     : (DIVIDER_DBZ_ERR_EN only) divide-by-zero flag
// -----------------------------------------------------------------------------
module seq_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DBZ_ERR_EN
  ,
  output logic             dbz
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shift_q;    // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [WIDTH-1:0] divisor_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

`ifdef DIVIDER_DBZ_ERR_EN
  logic             dbz_pend;
`endif

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shift_q[WIDTH-1]),
    .divisor (divisor_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign ready     = (state == ST_IDLE) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign accept    = ready && start;
  assign last_step = (state == ST_CALC) && (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (cnt_q == '0) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_CALC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      shift_q   <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIVIDER_DBZ_ERR_EN
      dbz_pend  <= 1'b0;
      dbz       <= 1'b0;
`endif
    end else if (accept) begin
      rem_q     <= '0;
      shift_q   <= dividend;
      divisor_q <= divisor;
      cnt_q     <= CW'(WIDTH - 1);
`ifdef DIVIDER_DBZ_ERR_EN
      dbz_pend  <= (divisor == '0);
`endif
    end else if (state == ST_CALC) begin
      rem_q   <= rem_next;
      shift_q <= {shift_q[WIDTH-2:0], q_bit};
      cnt_q   <= cnt_q - CW'(1);
      // Results are published on the same edge that enters DONE.
      if (last_step) begin
        quotient  <= {shift_q[WIDTH-2:0], q_bit};
        remainder <= rem_next;
`ifdef DIVIDER_DBZ_ERR_EN
        dbz       <= dbz_pend;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH=8). A behavioural model tracks
// each accepted request as a latency countdown carrying the arithmetic
// result (a/b, a%b, or all-ones/a for b=0); a compare process checks every
// output on every falling edge. Directed cases pin the model with literal
// results, then randomized traffic (including pokes while busy and
// occasional resets) runs against the model.
// Define DIVIDER_DBZ_ERR_EN to exercise the dbz output as well.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIVIDER_DBZ_ERR_EN
  logic             dbz;
`endif

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIVIDER_DBZ_ERR_EN
    ,
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_valid = 1'b0;
  bit               m_pending = 1'b0;
  int               m_left = 0;
  bit               m_done = 1'b0;
  logic [WIDTH-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit               m_dbz = 1'b0, p_dbz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 1'b1;
      m_pending = 1'b0;
      m_left    = 0;
      m_done    = 1'b0;
      m_q       = '0;
      m_r       = '0;
      m_dbz     = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pending) begin
        m_left--;
        if (m_left == 0) begin
          m_pending = 1'b0;
          m_done    = 1'b1;
          m_q       = p_q;
          m_r       = p_r;
          m_dbz     = p_dbz;
        end
      end else if (start) begin
        m_pending = 1'b1;
        m_left    = WIDTH;
        p_dbz     = (divisor == 0);
        if (divisor == 0) begin
          p_q = '1;
          p_r = dividend;
        end else begin
          p_q = dividend / divisor;
          p_r = dividend % divisor;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", ready, !m_pending);
      check("done", done, m_done);
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
`ifdef DIVIDER_DBZ_ERR_EN
      check("dbz", dbz, m_dbz);
`endif
    end
  end

  // ---------------- driver helpers ----------------
  // Presents one request for a single cycle; returns at the first falling
  // edge after the accept edge (CALC cycle 1), with operands scrambled.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
  endtask

  // Called in CALC cycle 1; cyc counts cycles after the accept edge up to the
  // done cycle, busy counts cycles with ready low on the way.
  task automatic wait_done(output int cyc, output int busy);
    cyc  = 1;
    busy = (ready == 1'b0) ? 1 : 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!ready) busy++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    int cyc, busy, seen;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    rst = 1'b0;

    // 200/7: latency and ready-low window
    op(200, 7);
    wait_done(cyc, busy);
    check("lat_200_7", cyc, 9);
    check("busy_200_7", busy, 8);
    check("q_200_7", quotient, 28);
    check("r_200_7", remainder, 4);

    op(255, 1);
    wait_done(cyc, busy);
    check("q_255_1", quotient, 255);
    check("r_255_1", remainder, 0);

    op(5, 9);
    wait_done(cyc, busy);
    check("q_5_9", quotient, 0);
    check("r_5_9", remainder, 5);

    // Divide by zero, then a normal division clears the flag
    op(100, 0);
    wait_done(cyc, busy);
    check("lat_100_0", cyc, 9);
    check("q_100_0", quotient, 255);
    check("r_100_0", remainder, 100);
`ifdef DIVIDER_DBZ_ERR_EN
    check("dbz_100_0", dbz, 1);
`endif
    op(12, 4);
    wait_done(cyc, busy);
    check("q_12_4", quotient, 3);
    check("r_12_4", remainder, 0);
`ifdef DIVIDER_DBZ_ERR_EN
    check("dbz_12_4", dbz, 0);
`endif

    // start during CALC is ignored
    op(50, 3);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 9;
    divisor  = 9;
    @(negedge clk);
    start    = 1'b0;
    wait_done(cyc, busy);
    check("q_50_3", quotient, 16);
    check("r_50_3", remainder, 2);

    // Back-to-back accept in the DONE cycle; previous result held meanwhile
    start    = 1'b1;
    dividend = 81;
    divisor  = 9;
    @(negedge clk);
    start    = 1'b0;
    check("b2b_accepted", ready, 0);
    check("b2b_hold_q", quotient, 16);
    check("b2b_hold_r", remainder, 2);
    wait_done(cyc, busy);
    check("lat_81_9", cyc, 9);
    check("q_81_9", quotient, 9);
    check("r_81_9", remainder, 0);

    // Reset mid-CALC discards the operation
    op(200, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midrst_no_done", seen, 0);
    op(17, 5);
    wait_done(cyc, busy);
    check("q_17_5", quotient, 3);
    check("r_17_5", remainder, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(2) == 0);
      dividend = WIDTH'($urandom);
      divisor  = ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom);
      rst      = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
